// File: rtl/oric_tape_player.sv
// Oric cassette transmitter: serialises TAP bytes into the fast tape waveform.
// Each bit is a high half-period followed by one (bit 1) or two (bit 0) low halves.
module oric_tape_player #(
   parameter int HALF_CYC  = 4992,
   parameter int STOP_BITS = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        motor,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        tape_out,
   output logic        busy,
   output logic [15:0] bytes_sent
);

   localparam int CW = $clog2(3 * HALF_CYC + 1);

   localparam logic [CW-1:0] H_END  = CW'(HALF_CYC);
   localparam logic [CW-1:0] END_1  = CW'(2 * HALF_CYC - 1);
   localparam logic [CW-1:0] END_0  = CW'(3 * HALF_CYC - 1);
   localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     idx_q, idx_d;
   logic [3:0]     stop_q, stop_d;
   logic [8:0]     sr_q, sr_d;
   logic [15:0]    sent_q;
   logic           tape_q, tape_d;
   logic           cur_bit;
   logic           bit_end;
   logic           accept;
   logic           done;

   assign byte_ready = (state_q == IDLE) & motor & ~reset;
   assign accept     = byte_valid & byte_ready;
   assign busy       = (state_q != IDLE);
   assign tape_out   = tape_q;
   assign bytes_sent = sent_q;

   // Value of the bit being sent decides how long its low phase lasts.
   always_comb begin
      cur_bit = sr_q[0];
      if (state_q == START) cur_bit = 1'b0;
      if (state_q == STOP)  cur_bit = 1'b1;
      bit_end = (cnt_q == (cur_bit ? END_1 : END_0));
   end

   // Next-state, datapath updates and the registered waveform level.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      stop_d  = stop_q;
      sr_d    = sr_q;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               state_d = START;
               sr_d    = {~^byte_data, byte_data};
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               sr_d  = {1'b0, sr_q[8:1]};
               if (idx_q == 3'd7) state_d = PARITY;
               else               idx_d   = idx_q + 1'b1;
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               cnt_d   = '0;
               stop_d  = '0;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (stop_q == S_LAST) begin
                  state_d = IDLE;
                  done    = 1'b1;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      tape_d = (state_d != IDLE) && (cnt_d < H_END);
   end

   // State and datapath registers; reset abandons any partial frame.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         stop_q  <= '0;
         sr_q    <= '0;
         sent_q  <= '0;
         tape_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         sr_q    <= sr_d;
         tape_q  <= tape_d;
         if (done) sent_q <= sent_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_oric_tape_player.sv
// Directed bench for oric_tape_player with HALF_CYC=4, STOP_BITS=4.
// A small waveform model is compared against tape_out cycle by cycle.
module tb_oric_tape_player;

   localparam int H = 4;
   localparam int SB = 4;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        motor = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        tape_out;
   logic        busy;
   logic [15:0] bytes_sent;

   int checks = 0;
   int failures = 0;
   bit exp_q[$];
   int w;
   int errs;

   oric_tape_player #(.HALF_CYC(H), .STOP_BITS(SB)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .motor      (motor),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .tape_out   (tape_out),
      .busy       (busy),
      .bytes_sent (bytes_sent)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic add_bit(input bit v);
      for (int i = 0; i < H; i++) exp_q.push_back(1'b1);
      for (int i = 0; i < (v ? H : 2 * H); i++) exp_q.push_back(1'b0);
   endtask

   task automatic build(input logic [7:0] b);
      exp_q.delete();
      add_bit(1'b0);
      for (int i = 0; i < 8; i++) add_bit(b[i]);
      add_bit((^b) ? 1'b0 : 1'b1);
      for (int i = 0; i < SB; i++) add_bit(1'b1);
   endtask

   // Sends one byte; aborts via reset at cycle abort_at, drops motor at drop_at.
   task automatic send(input logic [7:0] b, input int exp_len, input bit hold,
                       input int drop_at, input int abort_at,
                       input logic [15:0] sent_exp, output int waited);
      int e;
      logic b_last;
      build(b);
      byte_data = b;
      byte_valid = 1'b1;
      waited = 0;
      while (byte_ready !== 1'b1 && waited < 200) begin
         tick();
         waited++;
      end
      if (waited >= 200) begin
         chk("accept_timeout", 32'(waited), 0);
         byte_valid = 1'b0;
         return;
      end
      tick();
      if (!hold) byte_valid = 1'b0;
      e = 0;
      b_last = 1'b0;
      for (int i = 0; i < exp_len; i++) begin
         if (i > 0) tick();
         if (i + 1 == drop_at) motor = 1'b0;
         if (i + 1 == abort_at) begin
            reset = 1'b1;
            #1;
            chk("ready_in_reset", byte_ready, 0);
            tick();
            chk("abort_tape", tape_out, 0);
            chk("abort_busy", busy, 0);
            chk("abort_sent", bytes_sent, sent_exp);
            reset = 1'b0;
            return;
         end
         if (i >= exp_q.size() || tape_out !== exp_q[i]) e++;
         if (i == exp_len - 1) b_last = busy;
      end
      chk($sformatf("wave_%02h", b), 32'(e), 0);
      chk($sformatf("busy_last_%02h", b), b_last, 1);
      tick();
      chk($sformatf("busy_end_%02h", b), busy, 0);
      chk($sformatf("tape_end_%02h", b), tape_out, 0);
      chk($sformatf("sent_%02h", b), bytes_sent, sent_exp);
      chk($sformatf("ready_end_%02h", b), byte_ready, motor);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      motor = 1'b1;
      repeat (3) tick();
      chk("ready_during_reset", byte_ready, 0);
      reset = 1'b0;
      #1;
      chk("rst_tape", tape_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sent", bytes_sent, 0);
      chk("rst_ready", byte_ready, 1);

      send(8'h00, 148, 1'b0, 0, 50, 16'd0, w);
      byte_valid = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      byte_valid = 1'b0;
      #1;
      chk("rst_vs_valid_busy", busy, 0);
      tick();
      chk("rst_vs_valid_idle", busy, 0);

      send(8'hFF, 116, 1'b0, 0, 0, 16'd1, w);
      send(8'h01, 148, 1'b0, 0, 0, 16'd2, w);
      send(8'h00, 148, 1'b1, 0, 0, 16'd3, w);
      send(8'h03, 140, 1'b0, 0, 0, 16'd4, w);
      chk("stream_wait", 32'(w), 0);

      motor = 1'b0;
      byte_data = 8'h55;
      byte_valid = 1'b1;
      errs = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (byte_ready !== 1'b0 || tape_out !== 1'b0 || busy !== 1'b0) errs++;
      end
      chk("motor_off_hold", 32'(errs), 0);
      motor = 1'b1;
      #1;
      chk("motor_on_ready", byte_ready, 1);
      send(8'h55, 132, 1'b0, 20, 0, 16'd5, w);
      chk("motor_on_wait", 32'(w), 0);
      byte_valid = 1'b1;
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy !== 1'b0 || tape_out !== 1'b0) errs++;
      end
      chk("motor_off_after", 32'(errs), 0);
      byte_valid = 1'b0;
      motor = 1'b1;
      tick();

      force dut.sent_q = 16'hFFFF;
      tick();
      release dut.sent_q;
      chk("preload", bytes_sent, 16'hFFFF);
      send(8'hFF, 116, 1'b0, 0, 0, 16'h0000, w);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
